// File: rtl/dead_time_mc.sv
// Multi-channel complementary dead-time generator: one A/B gate pair per phase leg,
// with shadowed dead-time reload, latched fault shutdown and per-output polarity.
module dead_time_mc #(
  parameter int N_CH     = 3,
  parameter int DT_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          pwm,
  input  logic [N_CH*DT_WIDTH-1:0] dtime_a,
  input  logic [N_CH*DT_WIDTH-1:0] dtime_b,
  input  logic                     load,
  input  logic [N_CH-1:0]          pol_a,
  input  logic [N_CH-1:0]          pol_b,
  input  logic [N_CH-1:0]          pwm_en,
  input  logic [N_CH-1:0]          dt_en,
  input  logic                     fault,
  input  logic                     fault_clear,
  output logic [N_CH-1:0]          pwmout_a,
  output logic [N_CH-1:0]          pwmout_b,
  output logic                     fault_latched,
  output logic [N_CH-1:0]          dt_busy
);

  typedef enum logic [2:0] {SAFE, DT_A, ON_A, DT_B, ON_B} state_e;

  localparam logic [DT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DT_WIDTH-1:0] ONE_DT  = DT_WIDTH'(1);
  localparam logic [DT_WIDTH:0]   ONE_WD  = (DT_WIDTH + 1)'(1);

  logic fault_q, fault_d;

  // A new fault request always beats a simultaneous clear.
  assign fault_d       = fault | (fault_q & ~fault_clear);
  assign fault_latched = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [DT_WIDTH-1:0] da_q, da_d, db_q, db_d;
    logic                pend_q, pend_d, xfer;
    logic                dten_q;
    logic                act_a_q, act_a_d, act_b_q, act_b_d;
    logic                busy_q, busy_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE_DT;
      // Shadow values only move into the active registers outside a dead-time interval.
      xfer    = (pend_q | load) & (state_q inside {SAFE, ON_A, ON_B});
      da_d    = xfer ? dtime_a[i*DT_WIDTH +: DT_WIDTH] : da_q;
      db_d    = xfer ? dtime_b[i*DT_WIDTH +: DT_WIDTH] : db_q;
      pend_d  = (pend_q | load) & ~xfer;

      if (fault_d) begin
        state_d = SAFE;
        cnt_d   = '0;
      end else if (!dt_en[i]) begin
        state_d = pwm[i] ? ON_A : ON_B;
        cnt_d   = '0;
      end else if (!dten_q) begin
        state_d = SAFE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          SAFE: begin
            if (pwm[i] ? (cnt_q >= da_d) : (cnt_q >= db_d)) begin
              state_d = pwm[i] ? ON_A : ON_B;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ON_B: begin
            if (pwm[i]) begin
              state_d = (da_d == '0) ? ON_A : DT_A;
              cnt_d   = '0;
            end
          end
          // Returning to the side that last conducted needs no gap.
          DT_A: begin
            if (!pwm[i])                                state_d = ON_B;
            else if (({1'b0, cnt_q} + ONE_WD) >= {1'b0, da_q}) state_d = ON_A;
            else                                        cnt_d = cnt_inc;
          end
          ON_A: begin
            if (!pwm[i]) begin
              state_d = (db_d == '0) ? ON_B : DT_B;
              cnt_d   = '0;
            end
          end
          DT_B: begin
            if (pwm[i])                                 state_d = ON_A;
            else if (({1'b0, cnt_q} + ONE_WD) >= {1'b0, db_q}) state_d = ON_B;
            else                                        cnt_d = cnt_inc;
          end
          default: begin
            state_d = SAFE;
            cnt_d   = '0;
          end
        endcase
      end

      act_a_d = (state_d == ON_A) & pwm_en[i] & ~fault_d;
      act_b_d = (state_d == ON_B) & dt_en[i] & pwm_en[i] & ~fault_d;
      busy_d  = (state_d == DT_A) | (state_d == DT_B) | ((state_d == SAFE) & ~fault_d);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= SAFE;
        cnt_q   <= '0;
        da_q    <= '0;
        db_q    <= '0;
        pend_q  <= 1'b0;
        dten_q  <= 1'b1;
        act_a_q <= 1'b0;
        act_b_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        da_q    <= da_d;
        db_q    <= db_d;
        pend_q  <= pend_d;
        dten_q  <= dt_en[i];
        act_a_q <= act_a_d;
        act_b_q <= act_b_d;
        busy_q  <= busy_d;
      end
    end

    // Polarity is static configuration, so the inactive level tracks it even in reset.
    assign pwmout_a[i] = act_a_q ? pol_a[i] : ~pol_a[i];
    assign pwmout_b[i] = act_b_q ? pol_b[i] : ~pol_b[i];
    assign dt_busy[i]  = busy_q;
  end

endmodule

// File: tb/tb_dead_time_mc.sv
// Self-checking bench for dead_time_mc: directed scenarios plus a randomized run
// compared against a run-length behavioural model of the gate outputs.
module tb_dead_time_mc;
  localparam int N_CH     = 3;
  localparam int DT_WIDTH = 10;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [N_CH-1:0]          pwm = '0;
  logic [N_CH*DT_WIDTH-1:0] dtime_a = '0;
  logic [N_CH*DT_WIDTH-1:0] dtime_b = '0;
  logic                     load = 1'b0;
  logic [N_CH-1:0]          pol_a = '1;
  logic [N_CH-1:0]          pol_b = '1;
  logic [N_CH-1:0]          pwm_en = '1;
  logic [N_CH-1:0]          dt_en = '1;
  logic                     fault = 1'b0;
  logic                     fault_clear = 1'b0;
  logic [N_CH-1:0]          pwmout_a;
  logic [N_CH-1:0]          pwmout_b;
  logic                     fault_latched;
  logic [N_CH-1:0]          dt_busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dead_time_mc #(.N_CH(N_CH), .DT_WIDTH(DT_WIDTH)) dut (
    .clk(clk), .reset(reset), .pwm(pwm), .dtime_a(dtime_a), .dtime_b(dtime_b),
    .load(load), .pol_a(pol_a), .pol_b(pol_b), .pwm_en(pwm_en), .dt_en(dt_en),
    .fault(fault), .fault_clear(fault_clear), .pwmout_a(pwmout_a), .pwmout_b(pwmout_b),
    .fault_latched(fault_latched), .dt_busy(dt_busy)
  );

  function automatic logic [N_CH-1:0] lvl(input logic [N_CH-1:0] act, input logic [N_CH-1:0] pol);
    return ~(act ^ pol);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_dt(input int da, input int db);
    for (int i = 0; i < N_CH; i++) begin
      dtime_a[i*DT_WIDTH +: DT_WIDTH] = DT_WIDTH'(da);
      dtime_b[i*DT_WIDTH +: DT_WIDTH] = DT_WIDTH'(db);
    end
  endtask

  task automatic load_pulse();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Returns the cycle index (relative to the pwm edge) at which A became active on all channels.
  task automatic measure_gap(input int n0, output int gap);
    int n;
    n = n0;
    while (n < 40 && pwmout_a !== pol_a) begin
      step();
      n++;
    end
    gap = n;
  endtask

  // No cycle may ever drive both gates of a leg active.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      compared++;
      if ((~(pwmout_a ^ pol_a) & ~(pwmout_b ^ pol_b)) !== '0) begin
        mismatched++;
        $display("[TB] FAIL overlap t=%0t a=%b b=%b pol_a=%b pol_b=%b", $time, pwmout_a, pwmout_b, pol_a, pol_b);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; pwm = '0; pwm_en = '1; dt_en = '1; load = 1'b0;
    pol_a = 3'b101; pol_b = 3'b011; fault = 1'b0; fault_clear = 1'b0;
    set_all_dt(4, 5);
    repeat (3) step();
    compared++; if (pwmout_a !== 3'b010) begin mismatched++; $display("[TB] FAIL reset_a got=%b exp=%b", pwmout_a, 3'b010); end
    compared++; if (pwmout_b !== 3'b100) begin mismatched++; $display("[TB] FAIL reset_b got=%b exp=%b", pwmout_b, 3'b100); end
    compared++; if (fault_latched !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fault got=%b exp=0", fault_latched); end
    compared++; if (dt_busy !== '0) begin mismatched++; $display("[TB] FAIL reset_busy got=%b exp=000", dt_busy); end
  endtask

  task automatic test_startup();
    load  = 1'b1;
    reset = 1'b1;
    step();
    load = 1'b0;
    compared++; if (dt_busy !== '1) begin mismatched++; $display("[TB] FAIL startup_busy got=%b exp=111", dt_busy); end
    for (int n = 0; n < 8; n++) begin
      if (n > 0) step();
      compared++;
      if (pwmout_b !== lvl((n >= 5) ? '1 : '0, pol_b)) begin
        mismatched++; $display("[TB] FAIL startup_b n=%0d got=%b exp=%b", n, pwmout_b, lvl((n >= 5) ? '1 : '0, pol_b));
      end
      compared++;
      if (pwmout_a !== lvl('0, pol_a)) begin
        mismatched++; $display("[TB] FAIL startup_a n=%0d got=%b exp=%b", n, pwmout_a, lvl('0, pol_a));
      end
    end
  endtask

  task automatic test_rise_dead();
    pwm = '1;
    step();
    for (int n = 0; n < 6; n++) begin
      if (n > 0) step();
      compared++;
      if (pwmout_a !== lvl((n >= 4) ? '1 : '0, pol_a)) begin
        mismatched++; $display("[TB] FAIL rise_a n=%0d got=%b exp=%b", n, pwmout_a, lvl((n >= 4) ? '1 : '0, pol_a));
      end
      compared++;
      if (pwmout_b !== lvl('0, pol_b)) begin
        mismatched++; $display("[TB] FAIL rise_b n=%0d got=%b exp=%b", n, pwmout_b, lvl('0, pol_b));
      end
      compared++;
      if (dt_busy !== ((n <= 3) ? '1 : '0)) begin
        mismatched++; $display("[TB] FAIL rise_busy n=%0d got=%b", n, dt_busy);
      end
    end
    pwm = '0;
    repeat (8) step();
    set_all_dt(0, 5);
    load_pulse();
    step();
    pwm = '1;
    step();
    compared++; if (pwmout_a !== pol_a) begin mismatched++; $display("[TB] FAIL zero_dt_a got=%b exp=%b", pwmout_a, pol_a); end
    compared++; if (pwmout_b !== ~pol_b) begin mismatched++; $display("[TB] FAIL zero_dt_b got=%b exp=%b", pwmout_b, ~pol_b); end
  endtask

  task automatic test_glitch();
    set_all_dt(6, 5);
    load_pulse();
    pwm = '0;
    repeat (7) step();
    pwm = '1;
    step();
    compared++; if (pwmout_a !== ~pol_a || pwmout_b !== ~pol_b) begin
      mismatched++; $display("[TB] FAIL glitch_k got a=%b b=%b exp a=%b b=%b", pwmout_a, pwmout_b, ~pol_a, ~pol_b);
    end
    pwm = '0;
    for (int n = 0; n < 4; n++) begin
      step();
      compared++; if (pwmout_a !== ~pol_a || pwmout_b !== pol_b) begin
        mismatched++; $display("[TB] FAIL glitch_back n=%0d got a=%b b=%b exp a=%b b=%b", n, pwmout_a, pwmout_b, ~pol_a, pol_b);
      end
    end
  endtask

  task automatic test_shadow_load();
    int gap;
    set_all_dt(3, 5);
    load_pulse();
    step();
    pwm = '1;
    step();
    set_all_dt(8, 5);
    load_pulse();
    measure_gap(1, gap);
    compared++; if (gap !== 3) begin mismatched++; $display("[TB] FAIL shadow_old_gap got=%0d exp=3", gap); end
    pwm = '0;
    repeat (8) step();
    pwm = '1;
    step();
    measure_gap(0, gap);
    compared++; if (gap !== 8) begin mismatched++; $display("[TB] FAIL shadow_new_gap got=%0d exp=8", gap); end
    pwm = '0;
    repeat (8) step();
    pwm = '1;
    step();
    set_all_dt(2, 5);
    load_pulse();
    set_all_dt(5, 5);
    load_pulse();
    measure_gap(2, gap);
    compared++; if (gap !== 8) begin mismatched++; $display("[TB] FAIL shadow_inflight_gap got=%0d exp=8", gap); end
    pwm = '0;
    repeat (8) step();
    pwm = '1;
    step();
    measure_gap(0, gap);
    compared++; if (gap !== 5) begin mismatched++; $display("[TB] FAIL shadow_reload_gap got=%0d exp=5", gap); end
  endtask

  task automatic test_fault();
    int gap;
    pol_a = '0;
    pol_b = '1;
    step();
    compared++; if (pwmout_a !== 3'b000) begin mismatched++; $display("[TB] FAIL fault_pre_a got=%b exp=000", pwmout_a); end
    fault = 1'b1;
    step();
    fault = 1'b0;
    compared++; if (pwmout_a !== 3'b111 || pwmout_b !== 3'b000) begin
      mismatched++; $display("[TB] FAIL fault_outputs got a=%b b=%b exp a=111 b=000", pwmout_a, pwmout_b);
    end
    compared++; if (fault_latched !== 1'b1) begin mismatched++; $display("[TB] FAIL fault_set got=%b exp=1", fault_latched); end
    compared++; if (dt_busy !== '0) begin mismatched++; $display("[TB] FAIL fault_busy got=%b exp=000", dt_busy); end
    repeat (3) step();
    compared++; if (fault_latched !== 1'b1 || pwmout_a !== 3'b111 || pwmout_b !== 3'b000) begin
      mismatched++; $display("[TB] FAIL fault_hold got lat=%b a=%b b=%b exp lat=1 a=111 b=000", fault_latched, pwmout_a, pwmout_b);
    end
    fault = 1'b1; fault_clear = 1'b1;
    step();
    fault = 1'b0; fault_clear = 1'b0;
    step();
    compared++; if (fault_latched !== 1'b1) begin mismatched++; $display("[TB] FAIL fault_wins got=%b exp=1", fault_latched); end
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    compared++; if (fault_latched !== 1'b0) begin mismatched++; $display("[TB] FAIL fault_clear got=%b exp=0", fault_latched); end
    compared++; if (dt_busy !== '1) begin mismatched++; $display("[TB] FAIL clear_busy got=%b exp=111", dt_busy); end
    measure_gap(0, gap);
    compared++; if (gap !== 5) begin mismatched++; $display("[TB] FAIL clear_restart_gap got=%0d exp=5", gap); end
  endtask

  task automatic test_bypass();
    logic [N_CH-1:0] p;
    dt_en = '0;
    for (int n = 0; n < 10; n++) begin
      p = N_CH'($urandom);
      pwm = p;
      step();
      compared++; if (pwmout_a !== lvl(p, pol_a) || pwmout_b !== lvl('0, pol_b)) begin
        mismatched++; $display("[TB] FAIL bypass n=%0d got a=%b b=%b exp a=%b b=%b", n, pwmout_a, pwmout_b, lvl(p, pol_a), lvl('0, pol_b));
      end
    end
    dt_en = '1;
    step();
    compared++; if (dt_busy !== '1 || pwmout_a !== ~pol_a || pwmout_b !== ~pol_b) begin
      mismatched++; $display("[TB] FAIL bypass_exit got busy=%b a=%b b=%b", dt_busy, pwmout_a, pwmout_b);
    end
  endtask

  task automatic test_random();
    int da[N_CH], db[N_CH], run[N_CH], last_on[N_CH];
    logic in_safe[N_CH], prev_p[N_CH];
    logic [N_CH-1:0] exp_a, exp_b, exp_busy;
    logic p, on_a, on_b;
    for (int round = 0; round < 3; round++) begin
      reset = 1'b0; pwm_en = '1; dt_en = '1;
      pol_a = N_CH'($urandom); pol_b = N_CH'($urandom); pwm = N_CH'($urandom);
      for (int i = 0; i < N_CH; i++) begin
        da[i] = $urandom_range(0, 7); db[i] = $urandom_range(0, 7);
        dtime_a[i*DT_WIDTH +: DT_WIDTH] = DT_WIDTH'(da[i]);
        dtime_b[i*DT_WIDTH +: DT_WIDTH] = DT_WIDTH'(db[i]);
        run[i] = 0; last_on[i] = 0; in_safe[i] = 1'b1; prev_p[i] = 1'b0;
      end
      step();
      load = 1'b1;
      reset = 1'b1;
      for (int t = 0; t < 300; t++) begin
        step();
        for (int i = 0; i < N_CH; i++) begin
          p = pwm[i];
          run[i] = (run[i] == 0 || p != prev_p[i]) ? 1 : run[i] + 1;
          prev_p[i] = p;
          if (in_safe[i] && t >= (p ? da[i] : db[i])) begin
            in_safe[i] = 1'b0;
            last_on[i] = p ? 1 : 2;
          end
          on_a = !in_safe[i] && p && (last_on[i] == 1 || run[i] >= da[i] + 1);
          on_b = !in_safe[i] && !p && (last_on[i] == 2 || run[i] >= db[i] + 1);
          if (on_a) last_on[i] = 1;
          if (on_b) last_on[i] = 2;
          exp_a[i] = on_a & pwm_en[i];
          exp_b[i] = on_b & pwm_en[i];
          exp_busy[i] = in_safe[i] | ~(on_a | on_b);
        end
        compared++; if (pwmout_a !== lvl(exp_a, pol_a)) begin
          mismatched++; $display("[TB] FAIL rand_a r=%0d t=%0d got=%b exp=%b", round, t, pwmout_a, lvl(exp_a, pol_a));
        end
        compared++; if (pwmout_b !== lvl(exp_b, pol_b)) begin
          mismatched++; $display("[TB] FAIL rand_b r=%0d t=%0d got=%b exp=%b", round, t, pwmout_b, lvl(exp_b, pol_b));
        end
        compared++; if (dt_busy !== exp_busy) begin
          mismatched++; $display("[TB] FAIL rand_busy r=%0d t=%0d got=%b exp=%b", round, t, dt_busy, exp_busy);
        end
        load = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          if ($urandom_range(0, 3) == 0) pwm[i] = ~pwm[i];
          pwm_en[i] = ($urandom_range(0, 9) != 0);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_startup();
    test_rise_dead();
    test_glitch();
    test_shadow_load();
    test_fault();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dead_time_mc.md
Name: dead_time_mc

Overview:
- Multi-channel complementary dead-time generator: successor to the single-channel dead-time block.
- Takes N_CH carrier-comparator PWM bits and produces a complementary A/B pair per channel, with independent rise-edge (A) and fall-edge (B) dead times.
- Adds shadowed dead-time reload at a carrier-sync strobe, a latched fault shutdown, per-output polarity with a defined inactive level, and a safe start-up state.
- Sits between the PWM carrier/compare stage and the gate-driver pins.

Parameters:
N_CH, 3, number of channels (phase legs)
DT_WIDTH, 10, width of each dead-time count in clk cycles

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
pwm  in  N_CH  raw PWM per channel; 1 requests A on, 0 requests B on
dtime_a  in  N_CH*DT_WIDTH  shadow dead time before A turns on; channel i at [i*DT_WIDTH +: DT_WIDTH]
dtime_b  in  N_CH*DT_WIDTH  shadow dead time before B turns on; same packing
load  in  1  one-cycle strobe (carrier sync) requesting shadow-to-active transfer
pol_a  in  N_CH  1 = A active-high, 0 = active-low
pol_b  in  N_CH  1 = B active-high, 0 = active-low
pwm_en  in  N_CH  channel output enable
dt_en  in  N_CH  1 = dead-time mode; 0 = single-ended bypass
fault  in  1  synchronous fault request, level-sensitive
fault_clear  in  1  clears latched fault
pwmout_a  out  N_CH  gate output A
pwmout_b  out  N_CH  gate output B
fault_latched  out  1  latched fault status
dt_busy  out  N_CH  channel is in a dead-time interval

Behaviour:
- Per-channel FSM with states SAFE, DT_A, ON_A, DT_B, ON_B. Raw drive is a_raw=1 only in ON_A and b_raw=1 only in ON_B.
- Outputs are registered: pwmout_a = a_raw ? pol_a : ~pol_a when enabled. When pwm_en=0 or fault_latched=1, both outputs sit at their inactive level (~pol).
- Reset (reset=0, async): all FSMs go to SAFE, counters 0, active dead times 0, load pending cleared, fault_latched=0. Outputs go to the inactive level of the current pol inputs; dt_busy=0.
- SAFE: counter counts while both outputs are off. Exit to ON_A if pwm=1, or to ON_B if pwm=0, once count >= the active dead time for the target side. The first output therefore never asserts earlier than a full dead time after reset release.
- ON_B, pwm sampled 1 at posedge k: go to DT_A and clear the counter. B is off from posedge k. A asserts at posedge k+Da, where Da is the active dtime_a. Da=0 gives A on at posedge k (no gap).
- DT_A: counter increments each cycle; go to ON_A when count >= Da-1.
- DT_A, pwm returns to 0: go back to ON_B next cycle. A never conducted, so no dead time is inserted; this suppresses glitches.
- ON_A / DT_B / ON_B mirror the above with pwm=0 and Db.
- Counters saturate at 2^DT_WIDTH-1 and never wrap.
- dt_busy=1 in DT_A, DT_B, and SAFE-while-counting.
- Shadow load: load=1 sets a per-channel pending flag. Transfer dtime_a/dtime_b into the active registers on the first cycle the channel is in ON_A, ON_B or SAFE. A dead-time interval in progress always completes with its old value.
- load arriving while a transfer is pending: re-samples the shadow inputs at the time of transfer.
- Bypass (dt_en=0): a_raw follows pwm with 1 cycle latency; b_raw=0; FSM forced to ON_A/ON_B tracking pwm.
- Switching dt_en from 0 to 1: enter SAFE and apply the full dead time.
- Fault: fault=1 sampled at posedge k sets fault_latched at k; all outputs go inactive at posedge k. All FSMs are forced to SAFE with counter 0.
- fault_clear=1 with fault=0 clears the latch. Channels then exit SAFE only after a full dead time.
- fault and fault_clear both 1: fault wins.
- pwm_en=0: outputs inactive, FSM keeps running, so re-enable takes effect glitch-free with no extra dead time.

Test Plan:
- Reset release with pwm=0, Db=5: pwmout_b asserts exactly 5 cycles after the first posedge following release; pwmout_a stays inactive throughout.
- Da=4, pwm 0->1 at cycle k: B inactive at k, A active at k+4, dt_busy=1 for cycles k..k+3. Da=0: A active at k with no gap.
- pwm 1-cycle pulse with Da=6: A never asserts; B returns to active 1 cycle after pwm falls; no overlap in any cycle.
- Sequence load with dtime_a=8 during DT_A (old Da=3): current gap is 3 cycles; next rising gap is 8 cycles. Sequence a second load before transfer: the later value is used.
- Fault pulse mid-ON_A with pol_a=0, pol_b=1: outputs go a=1, b=0 at the fault cycle and hold. fault_clear together with fault keeps the latch. fault_clear alone restarts with a full dead time.
- Random pwm on all N_CH channels, random Da/Db and polarities: a_raw & b_raw never both 1, checked by assertion. Every off-to-on gap is >= its configured dead time.
